// File: rtl/img_loader_pkg.sv
// -----------------------------------------------------------------------------
// img_loader_pkg
// Shared definitions for the RAM image loader:
//   - loader_state_e : loader FSM states
//   - ASCII constants recognised by the image parser
//   - STRICT_HEX     : 1 when IMG_LOADER_STRICT_HEX_EN is defined
// Configuration macro: IMG_LOADER_STRICT_HEX_EN
// -----------------------------------------------------------------------------
package img_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_LINE = 3'd2,
      ST_LO   = 3'd3,
      ST_EOL  = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } loader_state_e;

   localparam logic [7:0] CH_HASH = 8'h23;  // '#'
   localparam logic [7:0] CH_NL   = 8'h0A;  // '\n'
   localparam logic [7:0] CH_CR   = 8'h0D;  // '\r'

`ifdef IMG_LOADER_STRICT_HEX_EN
   localparam logic STRICT_HEX = 1'b1;
`else
   localparam logic STRICT_HEX = 1'b0;
`endif

endpackage

// File: rtl/hex_nibble_dec.sv
// -----------------------------------------------------------------------------
// hex_nibble_dec
// Combinational ASCII -> hex nibble decoder.
// Ports:
//   char_i    in  8  ASCII character
//   is_hex_o  out 1  character is an accepted hex digit
//   nibble_o  out 4  decoded value (4'h0 when not a hex digit)
// Configuration macro: IMG_LOADER_STRICT_HEX_EN
//   defined   : 0-9, A-F and a-f are hex digits
//   undefined : 0-9 and A-F only (lowercase decodes as non-hex, value 0)
// -----------------------------------------------------------------------------
module hex_nibble_dec (
   input  logic [7:0] char_i,
   output logic       is_hex_o,
   output logic [3:0] nibble_o
);

   always_comb begin
      is_hex_o = 1'b0;
      nibble_o = 4'h0;
      if (char_i >= 8'h30 && char_i <= 8'h39) begin
         is_hex_o = 1'b1;
         nibble_o = char_i[3:0];
      end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
         // 'A' is 0x41, so the low nibble plus 9 gives 10..15
         is_hex_o = 1'b1;
         nibble_o = char_i[3:0] + 4'd9;
      end
`ifdef IMG_LOADER_STRICT_HEX_EN
      else if (char_i >= 8'h61 && char_i <= 8'h66) begin
         is_hex_o = 1'b1;
         nibble_o = char_i[3:0] + 4'd9;
      end
`endif
   end

endmodule

// File: rtl/ram_image_loader.sv
// -----------------------------------------------------------------------------
// ram_image_loader
// Boot-time loader: parses an ASCII image ('#' header lines, then one "HL" hex
// byte per line) delivered one character per valid/ready handshake, writes the
// bytes into a byte-wide RAM, records each segment's start address in an entry
// table and holds the CPU in reset until the image has loaded cleanly.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   start_i                 pulse: begin a load (ignored while loading)
//   char_valid_i/ready_o    character handshake; char_data_i, char_last_i
//   ram_we_o/addr_o/wdata_o registered RAM byte write
//   entry_we_o/idx_o/addr_o registered entry-table write
//   byte_cnt_o              bytes written this load (saturates at DEPTH)
//   cpu_rst_n_o             low holds the CPU in reset
//   done_o / err_o          sticky load status
// Configuration macro: IMG_LOADER_STRICT_HEX_EN (strict hex digit checking)
// Handshake: a character is consumed on a cycle where char_valid_i and
// char_ready_o are both high; ready depends only on the FSM state.
// -----------------------------------------------------------------------------
module ram_image_loader
   import img_loader_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int ENTRY_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              char_valid_i,
   output logic              char_ready_o,
   input  logic [7:0]        char_data_i,
   input  logic              char_last_i,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [7:0]        ram_wdata_o,
   output logic              entry_we_o,
   output logic [ENTRY_W-1:0] entry_idx_o,
   output logic [ADDR_W-1:0] entry_addr_o,
   output logic [ADDR_W:0]   byte_cnt_o,
   output logic              cpu_rst_n_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ENTRY_W:0]  IDX_FULL  = {1'b1, {ENTRY_W{1'b0}}};

   loader_state_e state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               full_q, full_d;     // last RAM location already written
   logic [ENTRY_W:0]   idx_q, idx_d;       // one extra bit to represent MAX_ENTRIES
   logic [ADDR_W:0]    cnt_q, cnt_d;
   logic [3:0]         hi_q, hi_d;
   logic               first_q, first_d;   // next non-CR char is the first of the load
   logic               ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
   logic [7:0]         ram_wdata_q, ram_wdata_d;
   logic               entry_we_q, entry_we_d;
   logic [ENTRY_W-1:0] entry_idx_q, entry_idx_d;
   logic [ADDR_W-1:0]  entry_addr_q, entry_addr_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               cpu_rst_n_q, cpu_rst_n_d;

   logic       accept, is_cr, is_nl, is_hash, is_hex, nib_ok;
   logic [3:0] nibble;

   hex_nibble_dec u_dec (
      .char_i   (char_data_i),
      .is_hex_o (is_hex),
      .nibble_o (nibble)
   );

   assign char_ready_o = (state_q == ST_HDR) || (state_q == ST_LINE) ||
                         (state_q == ST_LO)  || (state_q == ST_EOL);
   assign accept  = char_valid_i & char_ready_o;
   assign is_cr   = (char_data_i == CH_CR);
   assign is_nl   = (char_data_i == CH_NL);
   assign is_hash = (char_data_i == CH_HASH);
   // In legacy mode every char in a nibble position is taken (non-hex reads as 0)
   assign nib_ok  = is_hex | ~STRICT_HEX;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      full_d       = full_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      first_d      = first_q;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      entry_we_d   = 1'b0;
      entry_idx_d  = entry_idx_q;
      entry_addr_d = entry_addr_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_i) begin
               state_d = ST_HDR;
               addr_d  = '0;
               full_d  = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               first_d = 1'b1;
            end
         end
         ST_HDR: begin
            if (accept) begin
               if (is_cr) begin
                  if (char_last_i) state_d = ST_ERR;
               end else if (first_q && !is_hash) begin
                  state_d = ST_ERR;
               end else begin
                  first_d = 1'b0;
                  if (is_nl) begin
                     entry_we_d   = 1'b1;
                     entry_idx_d  = idx_q[ENTRY_W-1:0];
                     entry_addr_d = addr_q;
                     idx_d        = idx_q + 1'b1;
                     state_d      = char_last_i ? ST_DONE : ST_LINE;
                  end else if (char_last_i) begin
                     state_d = ST_ERR;
                  end
               end
            end
         end
         ST_LINE: begin
            if (accept) begin
               if (is_cr) begin
                  if (char_last_i) state_d = ST_ERR;
               end else if (is_nl) begin
                  if (char_last_i) state_d = ST_DONE;
               end else if (is_hash) begin
                  // No room for another entry: fail before any entry write
                  state_d = (char_last_i || idx_q == IDX_FULL) ? ST_ERR : ST_HDR;
               end else if (char_last_i || full_q || !nib_ok) begin
                  // full_q: RAM exhausted, refuse the byte rather than wrap
                  state_d = ST_ERR;
               end else begin
                  hi_d    = nibble;
                  state_d = ST_LO;
               end
            end
         end
         ST_LO: begin
            if (accept) begin
               if (is_cr) begin
                  if (char_last_i) state_d = ST_ERR;
               end else if (!nib_ok) begin
                  state_d = ST_ERR;
               end else begin
                  ram_we_d    = 1'b1;
                  ram_addr_d  = addr_q;
                  ram_wdata_d = {hi_q, nibble};
                  if (addr_q == ADDR_LAST) full_d = 1'b1;
                  else                     addr_d = addr_q + 1'b1;
                  if (cnt_q != DEPTH_CNT)  cnt_d  = cnt_q + 1'b1;
                  state_d = char_last_i ? ST_DONE : ST_EOL;
               end
            end
         end
         ST_EOL: begin
            if (accept) begin
               if (is_nl || is_cr) begin
                  if (char_last_i) state_d = ST_DONE;
                  else if (is_nl)  state_d = ST_LINE;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      done_d      = (state_d == ST_DONE);
      err_d       = (state_d == ST_ERR);
      cpu_rst_n_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         full_q       <= 1'b0;
         idx_q        <= '0;
         cnt_q        <= '0;
         hi_q         <= '0;
         first_q      <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         entry_we_q   <= 1'b0;
         entry_idx_q  <= '0;
         entry_addr_q <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cpu_rst_n_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         full_q       <= full_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         first_q      <= first_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         entry_we_q   <= entry_we_d;
         entry_idx_q  <= entry_idx_d;
         entry_addr_q <= entry_addr_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cpu_rst_n_q  <= cpu_rst_n_d;
      end
   end

   assign ram_we_o     = ram_we_q;
   assign ram_addr_o   = ram_addr_q;
   assign ram_wdata_o  = ram_wdata_q;
   assign entry_we_o   = entry_we_q;
   assign entry_idx_o  = entry_idx_q;
   assign entry_addr_o = entry_addr_q;
   assign byte_cnt_o   = cnt_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign cpu_rst_n_o  = cpu_rst_n_q;

endmodule

// File: tb/tb_ram_image_loader.sv
// -----------------------------------------------------------------------------
// tb_ram_image_loader
// Bench for ram_image_loader built with a 4-byte RAM (ADDR_W=2) and a
// 4-entry table (ENTRY_W=2) so the RAM-full and entry-full limits are reached
// with short images. Expected RAM and entry writes are queued as each image is
// driven and consumed by a monitor as the loader emits them.
// -----------------------------------------------------------------------------
module tb_ram_image_loader;

   localparam int ADDR_W  = 2;
   localparam int ENTRY_W = 2;
   localparam int W       = ADDR_W + 8;
   localparam int EW      = ENTRY_W + ADDR_W;

   logic               clk_i = 1'b0;
   logic               rst_n_i = 1'b0;
   logic               start_i = 1'b0;
   logic               char_valid_i = 1'b0;
   logic               char_ready_o;
   logic [7:0]         char_data_i = 8'h00;
   logic               char_last_i = 1'b0;
   logic               ram_we_o;
   logic [ADDR_W-1:0]  ram_addr_o;
   logic [7:0]         ram_wdata_o;
   logic               entry_we_o;
   logic [ENTRY_W-1:0] entry_idx_o;
   logic [ADDR_W-1:0]  entry_addr_o;
   logic [ADDR_W:0]    byte_cnt_o;
   logic               cpu_rst_n_o;
   logic               done_o;
   logic               err_o;

   logic [W-1:0]  exp_q[$];
   logic [EW-1:0] exp_e_q[$];
   int n_cmp = 0;
   int n_mis = 0;
   bit toggle = 1'b0;

   ram_image_loader #(.ADDR_W(ADDR_W), .ENTRY_W(ENTRY_W)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .start_i      (start_i),
      .char_valid_i (char_valid_i),
      .char_ready_o (char_ready_o),
      .char_data_i  (char_data_i),
      .char_last_i  (char_last_i),
      .ram_we_o     (ram_we_o),
      .ram_addr_o   (ram_addr_o),
      .ram_wdata_o  (ram_wdata_o),
      .entry_we_o   (entry_we_o),
      .entry_idx_o  (entry_idx_o),
      .entry_addr_o (entry_addr_o),
      .byte_cnt_o   (byte_cnt_o),
      .cpu_rst_n_o  (cpu_rst_n_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_w(input int a, input int d);
      logic [ADDR_W-1:0] av;
      logic [7:0]        dv;
      av = a[ADDR_W-1:0];
      dv = d[7:0];
      exp_q.push_back({av, dv});
   endtask

   task automatic push_e(input int i, input int a);
      logic [ENTRY_W-1:0] iv;
      logic [ADDR_W-1:0]  av;
      iv = i[ENTRY_W-1:0];
      av = a[ADDR_W-1:0];
      exp_e_q.push_back({iv, av});
   endtask

   // Monitor: every write strobe must match the head of its expected queue
   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (ram_we_o && entry_we_o) check_val("we_collide", 1, 0);
         if (ram_we_o) begin
            if (exp_q.size() == 0) check_val("ram_unexpected_write", {ram_addr_o, ram_wdata_o}, 32'hFFFF_FFFF);
            else check_val("ram_write", {ram_addr_o, ram_wdata_o}, exp_q.pop_front());
         end
         if (entry_we_o) begin
            if (exp_e_q.size() == 0) check_val("entry_unexpected_write", {entry_idx_o, entry_addr_o}, 32'hFFFF_FFFF);
            else check_val("entry_write", {entry_idx_o, entry_addr_o}, exp_e_q.pop_front());
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic send_char(input logic [7:0] c, input logic last);
      int n;
      n = 0;
      char_data_i  = c;
      char_last_i  = last;
      char_valid_i = 1'b1;
      @(negedge clk_i);
      while (!char_ready_o && n < 20) begin
         n++;
         @(negedge clk_i);
      end
      if (!char_ready_o) begin
         check_val("ready_timeout", 0, 1);
         char_valid_i = 1'b0;
         char_last_i  = 1'b0;
         return;
      end
      @(posedge clk_i); #1;
      char_valid_i = 1'b0;
      char_last_i  = 1'b0;
      if (toggle) begin
         @(posedge clk_i); #1;
      end
   endtask

   task automatic send_str(input string s, input logic last_on_final);
      for (int i = 0; i < s.len(); i++)
         send_char(s[i], last_on_final && (i == s.len() - 1));
   endtask

   task automatic check_status(input string tag, input logic d, input logic e,
                               input logic c, input int cnt);
      cycles(3);
      check_val({tag, "_done"}, done_o, d);
      check_val({tag, "_err"}, err_o, e);
      check_val({tag, "_cpu_rst_n"}, cpu_rst_n_o, c);
      check_val({tag, "_byte_cnt"}, byte_cnt_o, cnt);
      check_val({tag, "_ram_q_drained"}, exp_q.size(), 0);
      check_val({tag, "_entry_q_drained"}, exp_e_q.size(), 0);
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_ready"}, char_ready_o, 0);
      check_val({tag, "_ram_we"}, ram_we_o, 0);
      check_val({tag, "_entry_we"}, entry_we_o, 0);
      check_val({tag, "_done"}, done_o, 0);
      check_val({tag, "_err"}, err_o, 0);
      check_val({tag, "_cpu_rst_n"}, cpu_rst_n_o, 0);
      check_val({tag, "_byte_cnt"}, byte_cnt_o, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // reset
      cycles(2);
      check_idle("reset");
      rst_n_i = 1'b1;
      cycles(2);
      check_idle("post_reset");

      // 1: basic two-byte image
      push_e(0, 0); push_w(0, 8'h12); push_w(1, 8'h34);
      pulse_start();
      send_str("#\n12\n34\n", 1'b1);
      check_status("s1", 1, 0, 1, 2);

      // 2: two segments, start_i ignored mid-load
      push_e(0, 0); push_w(0, 8'hAB); push_e(1, 1); push_w(1, 8'hCD);
      pulse_start();
      send_str("#a\nAB\n", 1'b0);
      pulse_start();
      send_str("#b\nCD\n", 1'b1);
      check_status("s2", 1, 0, 1, 2);

      // 3: missing leading '#'
      pulse_start();
      send_str("1", 1'b0);
      check_status("s3", 0, 1, 0, 0);

      // 4: fifth byte into a 4-byte RAM fails, no wrap
      push_e(0, 0);
      push_w(0, 8'h00); push_w(1, 8'h11); push_w(2, 8'h22); push_w(3, 8'h33);
      pulse_start();
      send_str("#\n00\n11\n22\n33\n4", 1'b0);
      check_status("s4", 0, 1, 0, 4);

      // 5: non-hex low nibble
      push_e(0, 0);
      pulse_start();
`ifdef IMG_LOADER_STRICT_HEX_EN
      send_str("#\n1G", 1'b0);
      check_status("s5", 0, 1, 0, 0);
`else
      push_w(0, 8'h10);
      send_str("#\n1G\n", 1'b1);
      check_status("s5", 1, 0, 1, 1);
`endif

      // lowercase hex, CR dropping, last on the low-nibble char
      push_e(0, 0);
`ifdef IMG_LOADER_STRICT_HEX_EN
      push_w(0, 8'hAB);
`else
      push_w(0, 8'h00);
`endif
      push_w(1, 8'h78); push_w(2, 8'h5A);
      pulse_start();
      send_str("\r#\r\nab\n7\r8\r\n5A", 1'b1);
      check_status("lo_last", 1, 0, 1, 3);

      // entry table overflow: fifth header fails without an entry write
      push_e(0, 0); push_e(1, 0); push_e(2, 0); push_e(3, 0);
      pulse_start();
      send_str("#\n#\n#\n#\n#", 1'b0);
      check_status("entry_full", 0, 1, 0, 0);

      // 6: throttled valid, reset mid-load, then a clean reload
      toggle = 1'b1;
      push_e(0, 0); push_w(0, 8'h12);
      pulse_start();
      send_str("#\n12\n3", 1'b0);
      cycles(2);
      check_val("s6_pre_reset_q", exp_q.size() + exp_e_q.size(), 0);
      rst_n_i = 1'b0;
      #2;
      check_idle("s6_reset");
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      cycles(1);
      push_e(0, 0); push_w(0, 8'h12); push_w(1, 8'h34);
      pulse_start();
      send_str("#\n12\n34\n", 1'b1);
      check_status("s6", 1, 0, 1, 2);
      toggle = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Global guard against a stalled run
   initial begin
      #200000;
      check_val("global_timeout", 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
